// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link (receive demux and transmit mux).
// Latency: n/a (types, constants, and a constant function only).
// Backpressure: n/a. TDM_DEMUX_PARITY_EN adds one parity beat per frame.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    localparam int N_SLOTS_DEF = 16;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int PARITY_BEATS = 1;
`else
    localparam int PARITY_BEATS = 0;
`endif

    // Slot index width; the parity beat sits at index N_SLOTS and needs one more bit.
    function automatic int slot_w(input int n);
        return $clog2(n) + PARITY_BEATS;
    endfunction

endpackage

// File: rtl/tdm_demux_16_if.sv
// Serial beat input and parallel frame output of the TDM receive demux.
// Latency: n/a (wires only).
// Backpressure: none; the master drives beats, the slave consumes every accepted beat.
interface tdm_demux_16_if import tdm_pkg::*; #(
    parameter int N_SLOTS = N_SLOTS_DEF
) ();
    localparam int SEL_W = slot_w(N_SLOTS);

    logic               en_n;
    logic               din;
    logic               din_valid;
    logic               frame_sync;
    logic [N_SLOTS-1:0] dout;
    logic               frame_valid;
    logic [SEL_W-1:0]   slot;
    logic               locked;
    logic               sync_err;

    modport master (
        output en_n, din, din_valid, frame_sync,
        input  dout, frame_valid, slot, locked, sync_err
    );

    modport slave (
        input  en_n, din, din_valid, frame_sync,
        output dout, frame_valid, slot, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_counter.sv
// Slot index counter with clear / load-1 / increment controls and a last-slot flag.
// Latency: slot updates on the clock edge after a control is asserted.
// Backpressure: none; holds whenever no control is asserted.
module tdm_slot_counter import tdm_pkg::*; #(
    parameter int N_SLOTS = N_SLOTS_DEF,
    parameter int SEL_W   = slot_w(N_SLOTS),
    parameter int LAST    = N_SLOTS - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load1,
    input  logic             inc,
    input  logic             clr,
    output logic [SEL_W-1:0] slot,
    output logic             last
);

    // Clear wins over load, load over increment; wrap only happens through clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SEL_W'(1);
        end else if (inc) begin
            slot <= slot + SEL_W'(1);
        end
    end

    assign last = (slot == SEL_W'(LAST));

endmodule

// File: rtl/tdm_demux_16.sv
// Receive-side 16-slot TDM demux: steers serial beats into slots, presents whole frames on dout.
// Latency: dout/frame_valid/sync_err appear one cycle after the completing or offending beat.
// Backpressure: none; every beat with din_valid & ~en_n is consumed. TDM_DEMUX_PARITY_EN adds a parity beat.
module tdm_demux_16 import tdm_pkg::*; #(
    parameter int N_SLOTS = N_SLOTS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tdm_demux_16_if.slave        bus
);

    localparam int SEL_W = slot_w(N_SLOTS);
    // The final data bit goes straight to dout unless a parity beat follows it.
    localparam int SH_W  = N_SLOTS - 1 + PARITY_BEATS;
    localparam int LAST  = N_SLOTS - 1 + PARITY_BEATS;

    state_t             state, state_n;
    logic [SH_W-1:0]    shadow, shadow_n;
    logic [N_SLOTS-1:0] dout, dout_n;
    logic               frame_valid, fv_n;
    logic               sync_err, err_n;
    logic               load1, inc, clr;
    logic [SEL_W-1:0]   slot;
    logic               last;
    logic               accept;

    assign accept = bus.din_valid & ~bus.en_n;

    tdm_slot_counter #(
        .N_SLOTS (N_SLOTS),
        .SEL_W   (SEL_W),
        .LAST    (LAST)
    ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load1 (load1),
        .inc   (inc),
        .clr   (clr),
        .slot  (slot),
        .last  (last)
    );

`ifdef TDM_DEMUX_PARITY_EN
    logic par;

    // Running XOR of the frame's data bits; restarts with the slot-0 bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (load1) begin
            par <= bus.din;
        end else if (inc) begin
            par <= par ^ bus.din;
        end else if (clr) begin
            par <= 1'b0;
        end
    end
`endif

    // State, shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            shadow      <= '0;
            dout        <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            shadow      <= shadow_n;
            dout        <= dout_n;
            frame_valid <= fv_n;
            sync_err    <= err_n;
        end
    end

    // Framing decisions for the accepted beat; nothing moves when no beat is accepted.
    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        dout_n   = dout;
        fv_n     = 1'b0;
        err_n    = 1'b0;
        load1    = 1'b0;
        inc      = 1'b0;
        clr      = 1'b0;
        if (accept) begin
            case (state)
                HUNT: begin
                    if (bus.frame_sync) begin
                        shadow_n    = '0;
                        shadow_n[0] = bus.din;
                        load1       = 1'b1;
                        state_n     = SYNC;
                    end
                end
                SYNC: begin
                    if (slot == '0) begin
                        if (bus.frame_sync) begin
                            shadow_n[0] = bus.din;
                            load1       = 1'b1;
                        end else begin
                            err_n   = 1'b1;
                            state_n = HUNT;
                            clr     = 1'b1;
                        end
                    end else if (bus.frame_sync) begin
                        // Sync mid-frame: drop the partial frame and restart on this beat.
                        err_n       = 1'b1;
                        shadow_n    = '0;
                        shadow_n[0] = bus.din;
                        load1       = 1'b1;
                    end else if (last) begin
`ifdef TDM_DEMUX_PARITY_EN
                        if (bus.din == par) begin
                            dout_n = shadow;
                            fv_n   = 1'b1;
                        end else begin
                            err_n  = 1'b1;
                        end
`else
                        dout_n = {bus.din, shadow};
                        fv_n   = 1'b1;
`endif
                        clr = 1'b1;
                    end else begin
                        for (int k = 0; k < SH_W; k++) begin
                            if (slot == SEL_W'(k)) begin
                                shadow_n[k] = bus.din;
                            end
                        end
                        inc = 1'b1;
                    end
                end
                default: begin
                    state_n = HUNT;
                end
            endcase
        end
    end

    assign bus.dout        = dout;
    assign bus.frame_valid = frame_valid;
    assign bus.sync_err    = sync_err;
    assign bus.slot        = slot;
    assign bus.locked      = (state == SYNC);

endmodule

// File: tb/tb_tdm_demux_16.sv
// Bench for tdm_demux_16: directed framing scenarios plus randomized beats against a frame-level model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: none; TDM_DEMUX_PARITY_EN switches the model and stimulus to parity frames.
module tb_tdm_demux_16;
    import tdm_pkg::*;

    localparam int N  = 16;
    localparam int FL = N + PARITY_BEATS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tdm_demux_16_if #(.N_SLOTS(N)) bus ();

    tdm_demux_16 #(.N_SLOTS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // Frame-level reference: bits collected so far in the current frame.
    bit           m_locked;
    bit           m_cur[$];
    logic [N-1:0] m_dout;
    bit           m_fv;
    bit           m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_cur.delete();
        m_dout = '0;
        m_fv   = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_beat(input bit fs, input bit d);
        int ones;
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (!m_locked) begin
            if (fs) begin
                m_cur    = {d};
                m_locked = 1'b1;
            end
        end else if (m_cur.size() == 0) begin
            if (fs) begin
                m_cur = {d};
            end else begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end
        end else if (fs) begin
            m_err = 1'b1;
            m_cur = {d};
        end else begin
            m_cur.push_back(d);
            if (m_cur.size() == FL) begin
                ones = 0;
                foreach (m_cur[i]) ones += int'(m_cur[i]);
                if (PARITY_BEATS == 0 || (ones % 2) == 0) begin
                    for (int k = 0; k < N; k++) m_dout[k] = m_cur[k];
                    m_fv = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
                m_cur.delete();
            end
        end
    endtask

    function automatic int exp_slot();
        return m_locked ? m_cur.size() : 0;
    endfunction

    task automatic check_all();
        check("dout",        32'(bus.dout),        32'(m_dout));
        check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
        check("sync_err",    32'(bus.sync_err),    32'(m_err));
        check("slot",        32'(bus.slot),        32'(exp_slot()));
        check("locked",      32'(bus.locked),      32'(m_locked));
    endtask

    // One clock: drive after the falling edge, update the model at the rising edge, compare just after.
    task automatic cycle(input bit en_n, input bit vld, input bit fs, input bit d);
        @(negedge clk);
        bus.en_n       = en_n;
        bus.din_valid  = vld;
        bus.frame_sync = fs;
        bus.din        = d;
        @(posedge clk);
        if (vld && !en_n) begin
            model_beat(fs, d);
        end else begin
            m_fv  = 1'b0;
            m_err = 1'b0;
        end
        #1;
        check_all();
    endtask

    task automatic send_frame(input logic [N-1:0] bits, input bit bad_par);
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, i == 0, bits[i]);
        if (PARITY_BEATS != 0) cycle(1'b0, 1'b1, 1'b0, (^bits) ^ bad_par);
    endtask

    logic [N-1:0] bits;
    logic [31:0]  held_slot;

    initial begin
        bus.en_n       = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        bus.din        = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single frame 0xA5C3, one-cycle pulse
        send_frame(16'hA5C3, 1'b0);
        check("t1_dout", 32'(bus.dout), 32'h0000A5C3);
        check("t1_fv", 32'(bus.frame_valid), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_fv_drop", 32'(bus.frame_valid), 32'd0);

        // 2: back-to-back frames
        send_frame(16'hFFFF, 1'b0);
        check("t2_dout_a", 32'(bus.dout), 32'h0000FFFF);
        send_frame(16'h0001, 1'b0);
        check("t2_dout_b", 32'(bus.dout), 32'h00000001);
        check("t2_err", 32'(bus.sync_err), 32'd0);

        // 3: frame_sync on beat 7 resyncs
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, i == 0, 1'($urandom));
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("t3_err", 32'(bus.sync_err), 32'd1);
        check("t3_slot", 32'(bus.slot), 32'd1);
        for (int i = 1; i < FL; i++) cycle(1'b0, 1'b1, 1'b0, 1'($urandom));
        check("t3_fv", 32'(bus.frame_valid), 32'(PARITY_BEATS == 0 || m_fv));

        // 4: missing sync at slot 0 drops lock, unsynced beats ignored
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_err", 32'(bus.sync_err), 32'd1);
        check("t4_locked", 32'(bus.locked), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'($urandom));
        check("t4_still_hunt", 32'(bus.locked), 32'd0);
        send_frame(16'h1234, 1'b0);
        check("t4_relock", 32'(bus.dout), 32'h00001234);

        // 5: en_n pause mid-frame
        bits = 16'h5A3C;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, i == 0, bits[i]);
        held_slot = 32'(bus.slot);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'(i % 2), 1'($urandom), 1'($urandom));
            check("t5_hold", 32'(bus.slot), held_slot);
        end
        for (int i = 6; i < N; i++) cycle(1'b0, 1'b1, 1'b0, bits[i]);
        if (PARITY_BEATS != 0) cycle(1'b0, 1'b1, 1'b0, ^bits);
        check("t5_dout", 32'(bus.dout), 32'h00005A3C);

        // 6: async reset mid-frame
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, i == 0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_dout", 32'(bus.dout), 32'd0);
        check("t6_slot", 32'(bus.slot), 32'd0);
        check("t6_locked", 32'(bus.locked), 32'd0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
        send_frame(16'hC0DE, 1'b0);
        send_frame(16'h0BAD, 1'b1);
        check("t6_par_err", 32'(bus.sync_err), 32'd1);
        check("t6_par_hold", 32'(bus.dout), 32'h0000C0DE);
`endif

        // Randomized beats, sync mostly where a frame should start
        for (int c = 0; c < 2000; c++) begin
            bit en, vld, fs, at_start;
            en       = ($urandom_range(0, 9) == 0);
            vld      = ($urandom_range(0, 4) != 0);
            at_start = !m_locked || (m_cur.size() == 0);
            fs       = at_start ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 39) == 0);
            cycle(en, vld, fs, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
